diff_mux_core: RTL and testbench
================================

DIFF_MUX_CORE -- requirements
Module: diff_mux_core

Interface
REQ-001 Parameter N_IN, default 6, number of DDR input channels (2..16).
REQ-002 Parameter N_OUT, default 7, number of DDR output channels (1..16).
REQ-003 Parameter CNT_W, default 16, activity counter width (8..32).
REQ-004 clk  in  1  single clock; all logic is on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_diff_0  in  N_IN  rising-phase samples from the DDR input cells.
REQ-007 in_diff_180  in  N_IN  falling-phase samples from the DDR input cells.
REQ-008 out_diff_0  out  N_OUT  rising-phase drive to the DDR output cells.
REQ-009 out_diff_180  out  N_OUT  falling-phase drive to the DDR output cells.
REQ-010 cfg_valid  in  1  route-entry write request.
REQ-011 cfg_ready  out  1  write accepted when cfg_valid and cfg_ready are both high.
REQ-012 cfg_addr  in  clog2(N_OUT)  output channel index.
REQ-013 cfg_data  in  SRC_W+3  {swap, mode[1:0], src[SRC_W-1:0]}.
REQ-014 cfg_commit  in  1  one-cycle pulse that copies the shadow table to the active table.
REQ-015 cfg_err  out  1  sticky flag for rejected writes.

Function
REQ-016 Per-output route modes SHALL be: PASS=0 (copy src), INV=1 (inverted src), CONST0=2 (both phases 0), CONST1=3 (both phases 1).
REQ-017 With swap=1, out_diff_0 SHALL take the src 180 sample and out_diff_180 SHALL take the src 0 sample; swap SHALL be applied before inversion.
REQ-018 Outputs SHALL be registered; latency from input sample to output is exactly 1 cycle.
REQ-019 An accepted write SHALL update only shadow[cfg_addr]; the active routing SHALL stay unchanged until commit.
REQ-020 On cfg_commit, all N_OUT active entries SHALL update atomically in the same cycle, and output data SHALL use the new table from the next cycle.
REQ-021 A write and a commit in the same cycle SHALL both take effect, and the committed table SHALL include that write.
REQ-022 cfg_ready SHALL be low for the one cycle after a commit and high otherwise, except during reset.
REQ-023 A write with cfg_addr >= N_OUT, or with src >= N_IN and mode PASS/INV, SHALL be dropped and SHALL set cfg_err.
REQ-024 cfg_err SHALL clear only on rst.
REQ-025 A commit with no prior writes SHALL re-apply the shadow table unchanged; it is not an error.

Reset
REQ-026 While rst is high: shadow and active entries = CONST0/src 0/swap 0, out_diff_0 = 0, out_diff_180 = 0, cfg_ready = 0, cfg_err = 0, counters = 0.
REQ-027 cfg_ready SHALL go high in the first cycle after rst falls.
REQ-028 rst mid-configuration SHALL discard uncommitted shadow writes.

Configuration
REQ-029 Macro DIFF_MUX_ACT_CNT_EN SHALL compile in per-input activity counters, with ports cnt_sel (in, clog2(N_IN)), cnt_clr (in, 1) and cnt_value (out, CNT_W).
REQ-030 With the macro defined, each counter SHALL add the number of phase transitions per cycle: in_diff_0^in_diff_180 (0/1) plus prev in_diff_180^in_diff_0 (0/1).
REQ-031 With the macro defined, counters SHALL saturate at all-ones.
REQ-032 With the macro defined, cnt_value SHALL be registered with 1-cycle latency from cnt_sel.
REQ-033 With the macro defined, cnt_clr SHALL zero the selected counter, and clear SHALL win over a same-cycle increment.
REQ-034 Without the macro, the counter ports and all counter logic SHALL be absent.

Structure
REQ-035 Package diff_mux_pkg SHALL hold the mode enum, the route_entry_t struct {swap, mode, src} and the SRC_W function.
REQ-036 One sub-module diff_mux_route SHALL implement a single output's swap/invert/const datapath, instantiated N_OUT times.

Verification
REQ-037 Reset: assert rst 3 cycles -> all outputs 0, cfg_ready 0; cycle after release -> cfg_ready 1.
REQ-038 Write out2={swap0,PASS,src3}, no commit -> out2 stays 0; commit -> 1 cycle later out2 tracks in3 with 1-cycle latency.
REQ-039 Write out4={swap1,INV,src1} then commit; drive in1_0=1, in1_180=0 -> out4_0=1, out4_180=0.
REQ-040 Write addr 7 (N_OUT=7) and a separate src 6 PASS write -> both dropped, cfg_err=1, table unchanged.
REQ-041 Write and commit in the same cycle -> new entry active next cycle; cfg_ready 0 for exactly one cycle.
REQ-042 (DIFF_MUX_ACT_CNT_EN, CNT_W=8) Toggle in0 at 0/1 every phase for 200 cycles -> cnt_value = 255 (saturated); cnt_clr -> 0.

Source files
------------

// File: rtl/diff_mux_pkg.sv
// Shared types and helpers for the DDR differential mux.
// Contents:
//   route_mode_e  - per-output route mode (PASS / INV / CONST0 / CONST1)
//   route_entry_t - one routing-table entry {swap, mode, src}
//   sel_w/src_w   - index-width helpers (never narrower than 1 bit)
package diff_mux_pkg;

  // The widest legal source index (N_IN <= 16) fits in 4 bits. Entries store
  // the source at this fixed width so the struct needs no parameter.
  localparam int SRC_MAX_W = 4;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INV    = 2'd1,
    MODE_CONST0 = 2'd2,
    MODE_CONST1 = 2'd3
  } route_mode_e;

  typedef struct packed {
    logic                 swap;
    route_mode_e          mode;
    logic [SRC_MAX_W-1:0] src;
  } route_entry_t;

  localparam route_entry_t ROUTE_RESET = '{swap: 1'b0, mode: MODE_CONST0, src: '0};

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the source-select field carried in cfg_data.
  function automatic int src_w(input int n_in);
    return sel_w(n_in);
  endfunction

endpackage

// File: rtl/diff_mux_route.sv
// Combinational datapath for a single output channel: selects the source
// input pair, optionally swaps the phases, then inverts or forces a constant.
// Ports:
//   entry    - active routing entry for this output
//   in_0     - rising-phase input samples (all channels)
//   in_180   - falling-phase input samples (all channels)
//   out_0    - rising-phase result (registered by the parent)
//   out_180  - falling-phase result (registered by the parent)
module diff_mux_route
  import diff_mux_pkg::*;
#(
  parameter int N_IN = 6
) (
  input  route_entry_t    entry,
  input  logic [N_IN-1:0] in_0,
  input  logic [N_IN-1:0] in_180,
  output logic            out_0,
  output logic            out_180
);

  localparam int SRC_W = src_w(N_IN);

  logic src_ok;
  logic s_0;
  logic s_180;
  logic p_0;
  logic p_180;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    src_ok  = 1'b0;
    s_0     = 1'b0;
    s_180   = 1'b0;
    p_0     = 1'b0;
    p_180   = 1'b0;
    out_0   = 1'b0;
    out_180 = 1'b0;

    // CONST entries may carry any src value; never index past the inputs.
    src_ok = int'(entry.src) < N_IN;
    if (src_ok) begin
      s_0   = in_0[entry.src[SRC_W-1:0]];
      s_180 = in_180[entry.src[SRC_W-1:0]];
    end

    // Swap happens first so INV inverts the already-swapped phases.
    p_0   = entry.swap ? s_180 : s_0;
    p_180 = entry.swap ? s_0   : s_180;

    unique case (entry.mode)
      MODE_PASS:   begin out_0 = p_0;  out_180 = p_180;  end
      MODE_INV:    begin out_0 = ~p_0; out_180 = ~p_180; end
      MODE_CONST0: begin out_0 = 1'b0; out_180 = 1'b0;   end
      MODE_CONST1: begin out_0 = 1'b1; out_180 = 1'b1;   end
    endcase
  end

endmodule

// File: rtl/diff_mux_core.sv
// DDR differential crossbar with a double-buffered routing table.
// Writes land in a shadow table; cfg_commit copies it to the active table
// atomically. Each output is registered (1-cycle latency).
// Optional macro DIFF_MUX_ACT_CNT_EN adds saturating per-input activity
// counters readable through cnt_sel / cnt_value, clearable with cnt_clr.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_diff_0/in_diff_180     - rising/falling-phase input samples
//   out_diff_0/out_diff_180   - registered rising/falling-phase drive
//   cfg_valid/cfg_ready       - route-entry write handshake
//   cfg_addr, cfg_data        - output index, {swap, mode[1:0], src}
//   cfg_commit                - shadow -> active copy pulse
//   cfg_err                   - sticky flag for dropped writes
//   cnt_sel/cnt_clr/cnt_value - activity counter access (macro only)
module diff_mux_core
  import diff_mux_pkg::*;
#(
  parameter  int N_IN  = 6,
  parameter  int N_OUT = 7,
  parameter  int CNT_W = 16,
  localparam int SRC_W = src_w(N_IN),
  localparam int AW    = sel_w(N_OUT),
  localparam int CW    = sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_diff_0,
  input  logic [N_IN-1:0]  in_diff_180,
  output logic [N_OUT-1:0] out_diff_0,
  output logic [N_OUT-1:0] out_diff_180,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SRC_W+2:0] cfg_data,
  input  logic             cfg_commit,
  output logic             cfg_err
`ifdef DIFF_MUX_ACT_CNT_EN
  ,
  input  logic [CW-1:0]    cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_value
`endif
);

  if (N_IN < 2 || N_IN > 16 || N_OUT < 1 || N_OUT > 16 || CNT_W < 8 || CNT_W > 32)
  begin : g_bad_param
    $error("diff_mux_core: parameter out of range");
  end

  route_entry_t     shadow_q [N_OUT];
  route_entry_t     shadow_d [N_OUT];
  route_entry_t     active_q [N_OUT];
  route_entry_t     wr_entry;
  logic             addr_ok;
  logic             src_ok;
  logic             wr_take;
  logic             wr_ok;
  logic             wr_bad;
  logic [N_OUT-1:0] route_0;
  logic [N_OUT-1:0] route_180;

  // Decode the write and build the next shadow table. Commit copies
  // shadow_d, so a same-cycle write is part of the committed table.
  always_comb begin
    wr_entry.swap = cfg_data[SRC_W+2];
    wr_entry.mode = route_mode_e'(cfg_data[SRC_W+1:SRC_W]);
    wr_entry.src  = SRC_MAX_W'(cfg_data[SRC_W-1:0]);

    addr_ok = int'(cfg_addr) < N_OUT;
    // Constant modes ignore src, so an out-of-range src is harmless there.
    src_ok  = (wr_entry.mode == MODE_CONST0) || (wr_entry.mode == MODE_CONST1) ||
              (int'(wr_entry.src) < N_IN);
    wr_take = cfg_valid && cfg_ready;
    wr_ok   = wr_take && addr_ok && src_ok;
    wr_bad  = wr_take && !(addr_ok && src_ok);

    shadow_d = shadow_q;
    if (wr_ok) shadow_d[cfg_addr] = wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both tables are reset explicitly; a known CONST0 table is what
      // keeps the outputs quiet after reset and makes rst discard shadow writes.
      for (int i = 0; i < N_OUT; i++) begin
        shadow_q[i] <= ROUTE_RESET;
        active_q[i] <= ROUTE_RESET;
      end
      cfg_ready    <= 1'b0;
      cfg_err      <= 1'b0;
      out_diff_0   <= '0;
      out_diff_180 <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      shadow_q <= shadow_d;
      if (cfg_commit) active_q <= shadow_d;
      cfg_ready    <= !cfg_commit;
      if (wr_bad) cfg_err <= 1'b1;
      out_diff_0   <= route_0;
      out_diff_180 <= route_180;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_route
    diff_mux_route #(.N_IN(N_IN)) u_route (
      .entry   (active_q[g]),
      .in_0    (in_diff_0),
      .in_180  (in_diff_180),
      .out_0   (route_0[g]),
      .out_180 (route_180[g])
    );
  end

`ifdef DIFF_MUX_ACT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [N_IN-1:0]  prev_180_q;

  // Transitions per cycle: 0->180 within the cycle plus previous 180 -> this 0.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      logic [1:0]     inc;
      logic [CNT_W:0] sum;
      inc = {1'b0, in_diff_0[i] ^ in_diff_180[i]} + {1'b0, prev_180_q[i] ^ in_diff_0[i]};
      sum = {1'b0, cnt_q[i]} + (CNT_W+1)'(inc);
      cnt_d[i] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (cnt_clr && int'(cnt_sel) == i) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
      prev_180_q <= '0;
      cnt_value  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      prev_180_q <= in_diff_180;
      cnt_value  <= (int'(cnt_sel) < N_IN) ? cnt_q[cnt_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_diff_mux_core.sv
// Self-checking bench for diff_mux_core: reset checks, a directed vector
// table for the routing scenarios, a reset-discard sequence, randomized
// traffic against a reference model, and (with DIFF_MUX_ACT_CNT_EN) counters.
module tb_diff_mux_core;

  localparam int N_IN  = 6;
  localparam int N_OUT = 7;
  localparam int CNT_W = 8;
  localparam int SRC_W = 3;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_IN-1:0]  in_diff_0;
  logic [N_IN-1:0]  in_diff_180;
  logic [N_OUT-1:0] out_diff_0;
  logic [N_OUT-1:0] out_diff_180;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [AW-1:0]    cfg_addr;
  logic [SRC_W+2:0] cfg_data;
  logic             cfg_commit;
  logic             cfg_err;
`ifdef DIFF_MUX_ACT_CNT_EN
  logic [2:0]       cnt_sel;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_value;
`endif

  always #5 clk = ~clk;

  diff_mux_core #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_diff_0    (in_diff_0),
    .in_diff_180  (in_diff_180),
    .out_diff_0   (out_diff_0),
    .out_diff_180 (out_diff_180),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .cfg_err      (cfg_err)
`ifdef DIFF_MUX_ACT_CNT_EN
    ,
    .cnt_sel      (cnt_sel),
    .cnt_clr      (cnt_clr),
    .cnt_value    (cnt_value)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: routing tables as plain records, mode as an integer.
  typedef struct { bit swap; int mode; int src; } m_ent_t;
  m_ent_t           m_sh  [N_OUT];
  m_ent_t           m_act [N_OUT];
  bit               m_ready, m_err;
  logic [N_OUT-1:0] m_o0, m_o180;

  function automatic logic [1:0] ref_route(m_ent_t e, logic [N_IN-1:0] i0, logic [N_IN-1:0] i180);
    logic a, b, s0, s180;
    s0   = (e.src < N_IN) ? i0[e.src]   : 1'b0;
    s180 = (e.src < N_IN) ? i180[e.src] : 1'b0;
    a = e.swap ? s180 : s0;
    b = e.swap ? s0   : s180;
    if (e.mode == 0) return {a, b};
    if (e.mode == 1) return {~a, ~b};
    if (e.mode == 2) return 2'b00;
    return 2'b11;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OUT; i++) begin
      m_sh[i]  = '{swap: 1'b0, mode: 2, src: 0};
      m_act[i] = '{swap: 1'b0, mode: 2, src: 0};
    end
    m_ready = 0; m_err = 0; m_o0 = '0; m_o180 = '0;
  endtask

  task automatic model_edge();
    m_ent_t e;
    logic [1:0] r;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N_OUT; i++) begin
      r = ref_route(m_act[i], in_diff_0, in_diff_180);
      m_o0[i] = r[1]; m_o180[i] = r[0];
    end
    if (cfg_valid && m_ready) begin
      e.swap = cfg_data[5]; e.mode = int'(cfg_data[4:3]); e.src = int'(cfg_data[2:0]);
      if (int'(cfg_addr) < N_OUT && !(e.mode < 2 && e.src >= N_IN)) m_sh[cfg_addr] = e;
      else m_err = 1;
    end
    if (cfg_commit) m_act = m_sh;
    m_ready = !cfg_commit;
  endtask

  // One clock: update model with the inputs that the edge will see, then
  // sample the DUT 1 time unit after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input bit v, input int addr, input bit sw, input int mode,
                         input int src, input bit commit);
    logic [1:0] m;
    logic [2:0] s;
    m = 2'(mode);
    s = 3'(src);
    cfg_valid  = v;
    cfg_addr   = AW'(addr);
    cfg_data   = {sw, m, s};
    cfg_commit = commit;
  endtask

  typedef struct {
    bit v; int addr; bit sw; int mode; int src; bit commit;
    logic [N_IN-1:0] i0, i180;
    logic [N_OUT-1:0] e0, e180;
    bit er, ee;
  } vec_t;

  function automatic vec_t mk(bit v, int addr, bit sw, int mode, int src, bit commit,
                              logic [N_IN-1:0] i0, logic [N_IN-1:0] i180,
                              logic [N_OUT-1:0] e0, logic [N_OUT-1:0] e180, bit er, bit ee);
    vec_t t;
    t.v = v; t.addr = addr; t.sw = sw; t.mode = mode; t.src = src; t.commit = commit;
    t.i0 = i0; t.i180 = i180; t.e0 = e0; t.e180 = e180; t.er = er; t.ee = ee;
    return t;
  endfunction

  vec_t vecs [14];

  initial begin
    // Expected outputs reflect the active table before each row's edge.
    vecs[0]  = mk(1, 2, 0, 0, 3, 0, 6'b001000, 6'b000000, 7'b0000000, 7'b0000000, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 6'b001000, 6'b000000, 7'b0000000, 7'b0000000, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 6'b001000, 6'b001000, 7'b0000000, 7'b0000000, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 6'b001000, 6'b000000, 7'b0000100, 7'b0000000, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 6'b000000, 6'b001000, 7'b0000000, 7'b0000100, 1, 0);
    vecs[5]  = mk(1, 4, 1, 1, 1, 0, 6'b000010, 6'b000000, 7'b0000000, 7'b0000000, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 6'b000010, 6'b000000, 7'b0000000, 7'b0000000, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 6'b000010, 6'b000000, 7'b0010000, 7'b0000000, 1, 0);
    vecs[8]  = mk(1, 7, 0, 0, 0, 0, 6'b001010, 6'b000000, 7'b0010100, 7'b0000000, 1, 1);
    vecs[9]  = mk(1, 0, 0, 0, 6, 0, 6'b000000, 6'b000000, 7'b0010000, 7'b0010000, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 7'b0010000, 7'b0010000, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 7'b0010000, 7'b0010000, 1, 1);
    vecs[12] = mk(1, 0, 0, 3, 0, 1, 6'b000000, 6'b000000, 7'b0010000, 7'b0010000, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 7'b0010001, 7'b0010001, 1, 1);

    rst = 1'b1;
    in_diff_0 = '0; in_diff_180 = '0;
    set_cfg(0, 0, 0, 0, 0, 0);
`ifdef DIFF_MUX_ACT_CNT_EN
    cnt_sel = '0; cnt_clr = 1'b0;
`endif

    // Reset held 3 cycles with live inputs: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      in_diff_0 = N_IN'($urandom); in_diff_180 = N_IN'($urandom);
      step();
      check("rst_out0",  32'(out_diff_0),   32'h0);
      check("rst_out180", 32'(out_diff_180), 32'h0);
      check("rst_ready", 32'(cfg_ready),    32'h0);
      check("rst_err",   32'(cfg_err),      32'h0);
    end
    rst = 1'b0;
    in_diff_0 = '0; in_diff_180 = '0;
    step();
    check("ready_after_rst", 32'(cfg_ready), 32'h1);

    // Directed routing table.
    for (int i = 0; i < 14; i++) begin
      set_cfg(vecs[i].v, vecs[i].addr, vecs[i].sw, vecs[i].mode, vecs[i].src, vecs[i].commit);
      in_diff_0 = vecs[i].i0; in_diff_180 = vecs[i].i180;
      step();
      check($sformatf("vec%0d_out0", i),   32'(out_diff_0),   32'(vecs[i].e0));
      check($sformatf("vec%0d_out180", i), 32'(out_diff_180), 32'(vecs[i].e180));
      check($sformatf("vec%0d_ready", i),  32'(cfg_ready),    32'(vecs[i].er));
      check($sformatf("vec%0d_err", i),    32'(cfg_err),      32'(vecs[i].ee));
    end

    // Reset in the middle of configuration discards the uncommitted write.
    set_cfg(1, 1, 0, 3, 0, 0);
    step();
    set_cfg(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    check("midrst_err", 32'(cfg_err), 32'h0);
    check("midrst_out0", 32'(out_diff_0), 32'h0);
    rst = 1'b0;
    step();
    check("midrst_ready", 32'(cfg_ready), 32'h1);
    set_cfg(0, 0, 0, 0, 0, 1);
    in_diff_0 = '1; in_diff_180 = '1;
    step();
    set_cfg(0, 0, 0, 0, 0, 0);
    step();
    check("midrst_discard0",   32'(out_diff_0),   32'h0);
    check("midrst_discard180", 32'(out_diff_180), 32'h0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      in_diff_0 = N_IN'($urandom); in_diff_180 = N_IN'($urandom);
      set_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      step();
      check("rnd_out0",   32'(out_diff_0),   32'(m_o0));
      check("rnd_out180", 32'(out_diff_180), 32'(m_o180));
      check("rnd_ready",  32'(cfg_ready),    32'(m_ready));
      check("rnd_err",    32'(cfg_err),      32'(m_err));
    end
    rst = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

`ifdef DIFF_MUX_ACT_CNT_EN
    // Counter 0: clear, then toggle every phase (+2 per cycle) to saturation.
    cnt_sel = 3'd0;
    cnt_clr = 1'b1;
    in_diff_0 = '0; in_diff_180 = '0;
    step();
    cnt_clr = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_diff_0 = 6'b000001; in_diff_180 = 6'b000000;
      step();
    end
    step();
    check("cnt_saturated", 32'(cnt_value), 32'd255);
    // Clear wins over the same-cycle increment, then count exact transitions.
    cnt_clr = 1'b1;
    in_diff_0 = 6'b000001; in_diff_180 = 6'b000000;
    step();
    cnt_clr = 1'b0;
    in_diff_0 = 6'b000001; in_diff_180 = 6'b000001;
    step();
    check("cnt_cleared", 32'(cnt_value), 32'd0);
    in_diff_0 = '0; in_diff_180 = '0;
    step();
    check("cnt_one", 32'(cnt_value), 32'd1);
    step();
    check("cnt_prev_term", 32'(cnt_value), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
